// File: rtl/pio_sw_led_avmm_if.sv
// Avalon-MM slave bus bundle for the switch/LED PIO.
// The host side drives address/strobes/data and receives the registered read data.
interface pio_sw_led_avmm_if;
   logic [2:0]  avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [31:0] avs_readdata;

   modport master (
      output avs_address, avs_read, avs_write, avs_writedata,
      input  avs_readdata
   );

   modport slave (
      input  avs_address, avs_read, avs_write, avs_writedata,
      output avs_readdata
   );
endinterface

// File: rtl/pio_sw_led_avmm.sv
// Switch/LED PIO Avalon-MM slave: synchronised inputs, edge capture IRQ, LED set/clear.
// Define PIO_SW_DEBOUNCE_EN to insert the sampled debounce stage ahead of DATA_IN.
module pio_sw_led_avmm #(
   parameter int SW_WIDTH  = 16,
   parameter int LED_WIDTH = 16,
   parameter int DB_CYCLES = 500000,
   parameter int EDGE_MODE = 2
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset_n,
   pio_sw_led_avmm_if.slave     avs,
   output logic                 irq,
   input  logic [SW_WIDTH-1:0]  sw_in,
   output logic [LED_WIDTH-1:0] led_out
);

   logic [SW_WIDTH-1:0]  sync1;
   logic [SW_WIDTH-1:0]  sync;
   logic [SW_WIDTH-1:0]  db;
   logic [SW_WIDTH-1:0]  db_prev;
   logic [SW_WIDTH-1:0]  edge_det;
   logic [SW_WIDTH-1:0]  edge_cap;
   logic [SW_WIDTH-1:0]  irq_mask;
   logic [SW_WIDTH-1:0]  cap_clr;
   logic [LED_WIDTH-1:0] led_reg;
   logic [LED_WIDTH-1:0] led_nxt;
   logic [31:0]          rd_mux;
   logic                 wr_led;
   logic                 wr_mask;
   logic                 wr_cap;
   logic                 wr_set;
   logic                 wr_clr;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         sync1 <= '0;
         sync  <= '0;
      end else begin
         sync1 <= sw_in;
         sync  <= sync1;
      end
   end

`ifdef PIO_SW_DEBOUNCE_EN
   localparam int CW = $clog2(DB_CYCLES);

   logic [CW-1:0]       cnt;
   logic                tick;
   logic [SW_WIDTH-1:0] samp;
   logic [SW_WIDTH-1:0] db_r;
   logic [SW_WIDTH-1:0] agree;

   assign tick  = (cnt == CW'(DB_CYCLES - 1));
   assign agree = ~(sync ^ samp);

   // A bit only moves once two ticks in a row saw the same level.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         cnt  <= '0;
         samp <= '0;
         db_r <= '0;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (tick) begin
            samp <= sync;
            db_r <= (db_r & ~agree) | (sync & agree);
         end
      end
   end

   assign db = db_r;
`else
   assign db = sync;
`endif

   generate
      if (EDGE_MODE == 0) begin : g_rise
         assign edge_det = db & ~db_prev;
      end else if (EDGE_MODE == 1) begin : g_fall
         assign edge_det = ~db & db_prev;
      end else begin : g_both
         assign edge_det = db ^ db_prev;
      end
   endgenerate

   assign wr_led  = avs.avs_write && (avs.avs_address == 3'd1);
   assign wr_mask = avs.avs_write && (avs.avs_address == 3'd2);
   assign wr_cap  = avs.avs_write && (avs.avs_address == 3'd3);
   assign wr_set  = avs.avs_write && (avs.avs_address == 3'd4);
   assign wr_clr  = avs.avs_write && (avs.avs_address == 3'd5);
   assign cap_clr = wr_cap ? avs.avs_writedata[SW_WIDTH-1:0] : '0;

   always_comb begin
      led_nxt = led_reg;
      unique case (1'b1)
         wr_led:  led_nxt = avs.avs_writedata[LED_WIDTH-1:0];
         wr_set:  led_nxt = led_reg | avs.avs_writedata[LED_WIDTH-1:0];
         wr_clr:  led_nxt = led_reg & ~avs.avs_writedata[LED_WIDTH-1:0];
         default: led_nxt = led_reg;
      endcase
   end

   // Reads see register contents before any write in the same cycle.
   always_comb begin
      rd_mux = '0;
      case (avs.avs_address)
         3'd0:    rd_mux[SW_WIDTH-1:0]  = db;
         3'd1:    rd_mux[LED_WIDTH-1:0] = led_reg;
         3'd2:    rd_mux[SW_WIDTH-1:0]  = irq_mask;
         3'd3:    rd_mux[SW_WIDTH-1:0]  = edge_cap;
         default: rd_mux = '0;
      endcase
   end

   // New edges take priority over a W1C on the same bit.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         db_prev          <= '0;
         edge_cap         <= '0;
         irq_mask         <= '0;
         irq              <= 1'b0;
         led_reg          <= '0;
         avs.avs_readdata <= '0;
      end else begin
         db_prev  <= db;
         edge_cap <= (edge_cap & ~cap_clr) | edge_det;
         irq      <= |(edge_cap & irq_mask);
         led_reg  <= led_nxt;
         if (wr_mask)
            irq_mask <= avs.avs_writedata[SW_WIDTH-1:0];
         avs.avs_readdata <= avs.avs_read ? rd_mux : '0;
      end
   end

   assign led_out = led_reg;

endmodule

// File: doc/pio_sw_led_avmm.md
Name: pio_sw_led_avmm

Overview:
- Parametrised Avalon-MM slave that replaces fixed-width switch/LED PIOs in the NIOS II system.
- Synchronises and debounces SW_WIDTH switch inputs.
- Captures edges per channel and raises a maskable interrupt.
- Drives LED_WIDTH outputs through a register with atomic set and clear aliases.
- Sits inside the Qsys system; exports conduits to board SW and LEDR.

Parameters:
- SW_WIDTH, 16: number of switch inputs, 1..32.
- LED_WIDTH, 16: number of LED outputs, 1..32.
- DB_CYCLES, 500000: debounce sample period in clk_clk cycles, 10 ms at 50 MHz, minimum 2.
- EDGE_MODE, 2: edge capture mode; 0 = rising, 1 = falling, 2 = both.

Ports:
- clk_clk, input, 1: system clock.
- reset_reset_n, input, 1: asynchronous active-low reset.
- avs_address, input, 3: word address.
- avs_read, input, 1: read strobe.
- avs_write, input, 1: write strobe.
- avs_writedata, input, 32: write data.
- avs_readdata, output, 32: read data, fixed latency 1.
- irq, output, 1: level interrupt, active high.
- sw_in, input, SW_WIDTH: raw asynchronous switch inputs.
- led_out, output, LED_WIDTH: LED drive.

Behaviour:
- Reset (asynchronous, active low): all registers clear to 0. That covers led_out, irq, avs_readdata, edge capture, mask, debounced state, sync flops, prescaler and sample register.
- Input path: 2-FF synchroniser per bit produces sync.
- Debounce prescaler: counts 0..DB_CYCLES-1 and wraps; tick is asserted on the wrap cycle.
- On each tick: samp <= sync. For each bit i with sync[i] == samp[i], db[i] <= sync[i].
- Debounce latency: an input held stable reaches db within 2*DB_CYCLES+3 cycles. A glitch shorter than DB_CYCLES never reaches db.
- Edge detect: db_prev <= db every cycle. Per bit, an edge is:
  - db & ~db_prev for EDGE_MODE 0;
  - ~db & db_prev for EDGE_MODE 1;
  - db ^ db_prev for EDGE_MODE 2.
- Detected edges OR into EDGE_CAP.
- irq is registered: irq <= |(EDGE_CAP & IRQ_MASK), so it lags the capture by 1 cycle.
- Register map (word address; bits above the channel width read 0 and are ignored on write):
  - 0 DATA_IN: read-only, returns db.
  - 1 LED_OUT: read/write.
  - 2 IRQ_MASK: read/write, SW_WIDTH bits.
  - 3 EDGE_CAP: read; a write clears bits written as 1 (W1C).
  - 4 LED_SET: write-only, LED_OUT <= LED_OUT | wdata; reads 0.
  - 5 LED_CLR: write-only, LED_OUT <= LED_OUT & ~wdata; reads 0.
  - 6, 7: reserved; read 0, writes ignored.
- led_out = LED_OUT register, driven directly from the flop with no combinational path.
- Read: avs_readdata is valid the cycle after avs_read. It holds 0 on any cycle not following a read.
- Read and write in the same cycle: the write commits and the read returns the pre-write value.
- W1C clear and new edge on the same bit in the same cycle: the set wins, bit stays 1.
- Reset asserted mid-debounce: the pending change is discarded. After release, db = 0 until stable samples are taken.

Optional Feature:
- Macro: PIO_SW_DEBOUNCE_EN.
- Defined: debounce path as above.
- Undefined:
  - prescaler, samp and debounce logic are omitted and db = sync;
  - latency from sw_in to DATA_IN is 2 cycles plus 1 read cycle;
  - DB_CYCLES is ignored.

Test Plan:
1. Reset then read all addresses 0..7 → readdata 0 each, led_out 0, irq 0.
2. DB_CYCLES=4, EDGE_MODE=2, debounce enabled. Set sw_in=16'h0005 stable, then read addr 0 after 12 cycles → 32'h00000005. Read addr 3 → 32'h00000005.
3. DB_CYCLES=4. Pulse sw_in[3] high for 2 cycles → DATA_IN bit 3 stays 0 and EDGE_CAP bit 3 stays 0 throughout.
4. Write addr 1 = 32'h0000F0F0, then addr 4 = 32'h0000000F, then addr 5 = 32'h000000F0 → led_out 16'hF0F0, 16'hF0FF, 16'hF00F on successive writes. Read addr 1 returns 32'h0000F00F.
5. Write IRQ_MASK = 1, then toggle sw_in[0] → irq rises 1 cycle after EDGE_CAP[0] sets. Write addr 3 = 1 → irq falls next cycle. Repeat with mask 0 → irq stays 0.
6. Drive a W1C of EDGE_CAP[1] in the same cycle a new edge on bit 1 is detected → EDGE_CAP[1] reads 1. Separately, assert reset_reset_n low for 1 cycle mid-debounce → all outputs 0 immediately, without waiting for a clock edge.
